dmem_responder: RTL

Data-memory responder for the single-cycle RISC-V core. It serves the `MemRead`/`MemWrite` requests the controller issues and drives `busy` combinationally, so the controller stalls its PC until each access completes. The block holds a word-addressed data array and models a fixed multi-cycle access latency with a small FSM and counter. It sits between the datapath (ALU result as address, RS2 value as write data) and the register-file write-back mux (`rdata`).

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed multi-cycle access latency; busy stalls the core until DONE.
// Optional one-entry last-access buffer under `DMEM_HIT_BUF_EN` serves repeated reads with zero busy cycles.
module dmem_responder #(
  parameter int NBITS   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] address,
  input  logic [NBITS-1:0] wdata,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [NBITS-1:0] rdata,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [NBITS-1:0] addr_q, wdata_q, rdata_q;
  logic             we_q;
  logic [NBITS-1:0] mem [2**NBITS];

  logic             req, hit, accept, commit, commit_we;
  logic [NBITS-1:0] commit_addr, commit_wdata, hit_data;

  assign req = MemRead | MemWrite;

`ifdef DMEM_HIT_BUF_EN
  logic             buf_vld;
  logic [NBITS-1:0] buf_tag, buf_data;

  assign hit      = (state == S_IDLE) && MemRead && !MemWrite && buf_vld && (buf_tag == address);
  assign hit_data = buf_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if (commit) begin
      buf_vld  <= 1'b1;
      buf_tag  <= commit_addr;
      buf_data <= commit_we ? commit_wdata : mem[commit_addr];
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign rdata = hit ? hit_data : rdata_q;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    commit       = 1'b0;
    commit_addr  = addr_q;
    commit_wdata = wdata_q;
    commit_we    = we_q;
    busy         = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && !hit) begin
          busy    = 1'b1;
          accept  = 1'b1;
          cnt_nxt = CNT_LOAD;
          // Single-cycle latency commits straight from the live request
          if (LATENCY == 1) begin
            commit       = 1'b1;
            commit_addr  = address;
            commit_wdata = wdata;
            commit_we    = MemWrite;
            state_nxt    = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy    = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      busy   = 1'b0;
      commit = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= address;
        wdata_q <= wdata;
        we_q    <= MemWrite;
      end
      if (commit && !commit_we)
        rdata_q <= mem[commit_addr];
      else if (hit)
        rdata_q <= hit_data;
    end
  end

  // Array is intentionally not reset; commit is already suppressed while reset is high
  always_ff @(posedge clock) begin
    if (commit && commit_we)
      mem[commit_addr] <= commit_wdata;
  end

endmodule
